// File: rtl/pong_sound_if.sv
// Game-dynamics to sound-block link: mute/sound requests in, buzzer/busy/code status out.
// The sound block connects through the slave modport, the game side through master.
interface pong_sound_if;
  logic       mute;
  logic [1:0] sound;
  logic       buzzer;
  logic       busy;
  logic [1:0] code_q;

  modport master (output mute, output sound, input buzzer, input busy, input code_q);
  modport slave  (input mute, input sound, output buzzer, output busy, output code_q);
endinterface

// File: rtl/pong_sound.sv
// Pong tone generator: wall/paddle square tones and a two-note goal sweep on one buzzer pin.
// Inputs are double-synchronised; buzzer/busy react 3 clocks after a pin change, and no backpressure applies.
module pong_sound #(
  parameter int HALF_WALL    = 25000,
  parameter int HALF_PADDLE  = 12500,
  parameter int HALF_GOAL_HI = 50000,
  parameter int HALF_GOAL_LO = 100000,
  parameter int GOAL_STEP    = 2500000
) (
  input  logic         clk,
  input  logic         reset,
  pong_sound_if.slave  bus
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXP = max2(max2(max2(HALF_WALL, HALF_PADDLE), max2(HALF_GOAL_HI, HALF_GOAL_LO)), GOAL_STEP);
  localparam int CW   = (MAXP > 1) ? $clog2(MAXP) : 1;

  typedef logic [CW-1:0] cnt_t;
  typedef enum logic [1:0] {IDLE, TONE, GOAL_HI, GOAL_LO} state_t;

  state_t     state_q, state_d;
  logic [1:0] code_q, code_d;
  cnt_t       half_q, half_d;
  cnt_t       step_q, step_d;
  logic       buzzer_q, buzzer_d;
  logic       busy_q, busy_d;

  logic       mute_meta_q, mute_s_q;
  logic [1:0] sound_meta_q, sound_s_q;

  cnt_t lim;
  logic start, stop;

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    half_d   = half_q;
    step_d   = step_q;
    buzzer_d = buzzer_q;
    lim      = '0;

    case (state_q)
      TONE:    lim = (code_q == 2'd1) ? cnt_t'(HALF_WALL - 1) : cnt_t'(HALF_PADDLE - 1);
      GOAL_HI: lim = cnt_t'(HALF_GOAL_HI - 1);
      GOAL_LO: lim = cnt_t'(HALF_GOAL_LO - 1);
      default: lim = '0;
    endcase

    // A stop request outranks a code change arriving on the same cycle.
    stop  = (state_q != IDLE) && (mute_s_q || (sound_s_q == 2'd0));
    start = !mute_s_q && (sound_s_q != 2'd0) && ((state_q == IDLE) || (sound_s_q != code_q));

    if (stop) begin
      state_d  = IDLE;
      code_d   = 2'd0;
      half_d   = '0;
      step_d   = '0;
      buzzer_d = 1'b0;
    end else if (start) begin
      state_d  = (sound_s_q == 2'd3) ? GOAL_HI : TONE;
      code_d   = sound_s_q;
      half_d   = '0;
      step_d   = '0;
      buzzer_d = 1'b1;
    end else if (state_q != IDLE) begin
      if (half_q == lim) begin
        half_d   = '0;
        buzzer_d = ~buzzer_q;
      end else begin
        half_d = half_q + 1'b1;
      end
      if (state_q == GOAL_HI) begin
        if (step_q == cnt_t'(GOAL_STEP - 1)) begin
          state_d  = GOAL_LO;
          half_d   = '0;
          step_d   = '0;
          buzzer_d = 1'b1;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Synchronisers come up muted so a stale request cannot start a tone.
      mute_meta_q  <= 1'b1;
      mute_s_q     <= 1'b1;
      sound_meta_q <= 2'd0;
      sound_s_q    <= 2'd0;
      state_q      <= IDLE;
      code_q       <= 2'd0;
      half_q       <= '0;
      step_q       <= '0;
      buzzer_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      mute_meta_q  <= bus.mute;
      mute_s_q     <= mute_meta_q;
      sound_meta_q <= bus.sound;
      sound_s_q    <= sound_meta_q;
      state_q      <= state_d;
      code_q       <= code_d;
      half_q       <= half_d;
      step_q       <= step_d;
      buzzer_q     <= buzzer_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.buzzer = buzzer_q;
  assign bus.busy   = busy_q;
  assign bus.code_q = code_q;

endmodule

// File: tb/tb_pong_sound.sv
// Directed vector bench for pong_sound with shortened tone periods.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_pong_sound;
  logic clk = 1'b0;
  logic reset;

  pong_sound_if bus();

  pong_sound #(
    .HALF_WALL(4), .HALF_PADDLE(2), .HALF_GOAL_HI(3), .HALF_GOAL_LO(5), .GOAL_STEP(12)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       mute;
    logic [1:0] snd;
    logic       buz;
    logic       bsy;
    logic [1:0] code;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   step_no  = 0;

  task automatic add(input logic r, input logic m, input logic [1:0] s,
                     input logic eb, input logic ey, input logic [1:0] ec);
    vec_t v;
    v.rst = r; v.mute = m; v.snd = s; v.buz = eb; v.bsy = ey; v.code = ec;
    tbl.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    reset     = v.rst;
    bus.mute  = v.mute;
    bus.sound = v.snd;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.buzzer === v.buz && bus.busy === v.bsy && bus.code_q === v.code) begin
      n_pass++;
    end else begin
      $display("FAIL step%0d buzzer/busy/code_q got %b/%b/%0d want %b/%b/%0d",
               step_no, bus.buzzer, bus.busy, bus.code_q, v.buz, v.bsy, v.code);
    end
    step_no++;
  endtask

  task automatic hand(input logic r, input logic m, input logic [1:0] s,
                      input logic eb, input logic ey, input logic [1:0] ec);
    vec_t v;
    v.rst = r; v.mute = m; v.snd = s; v.buz = eb; v.bsy = ey; v.code = ec;
    apply(v);
  endtask

  initial begin
    reset     = 1'b1;
    bus.mute  = 1'b1;
    bus.sound = 2'd0;

    // Reset, then wall tone: starts 3 clocks after the request, toggles every 4.
    add(1,1,0, 0,0,0);
    add(0,0,1, 0,0,0); add(0,0,1, 0,0,0); add(0,0,1, 1,1,1);
    add(0,0,1, 1,1,1); add(0,0,1, 1,1,1); add(0,0,1, 1,1,1);
    add(0,0,1, 0,1,1); add(0,0,1, 0,1,1); add(0,0,1, 0,1,1); add(0,0,1, 0,1,1);
    add(0,0,1, 1,1,1);
    // Switch to paddle: restart with buzzer high, toggles every 2.
    add(0,0,2, 1,1,1); add(0,0,2, 1,1,1); add(0,0,2, 1,1,2); add(0,0,2, 1,1,2);
    add(0,0,2, 0,1,2); add(0,0,2, 0,1,2); add(0,0,2, 1,1,2); add(0,0,2, 1,1,2);
    // Goal: period 3 for 12 clocks, then period 5 with code still 3.
    add(0,0,3, 0,1,2); add(0,0,3, 0,1,2);
    add(0,0,3, 1,1,3); add(0,0,3, 1,1,3); add(0,0,3, 1,1,3);
    add(0,0,3, 0,1,3); add(0,0,3, 0,1,3); add(0,0,3, 0,1,3);
    add(0,0,3, 1,1,3); add(0,0,3, 1,1,3); add(0,0,3, 1,1,3);
    add(0,0,3, 0,1,3); add(0,0,3, 0,1,3); add(0,0,3, 0,1,3);
    add(0,0,3, 1,1,3); add(0,0,3, 1,1,3); add(0,0,3, 1,1,3); add(0,0,3, 1,1,3); add(0,0,3, 1,1,3);
    add(0,0,3, 0,1,3); add(0,0,3, 0,1,3); add(0,0,3, 0,1,3); add(0,0,3, 0,1,3); add(0,0,3, 0,1,3);
    add(0,0,3, 1,1,3);
    // sound=0 acts as stop.
    add(0,0,0, 1,1,3); add(0,0,0, 1,1,3); add(0,0,0, 0,0,0);
    // Mute during the first goal note.
    add(0,0,3, 0,0,0); add(0,0,3, 0,0,0); add(0,0,3, 1,1,3); add(0,0,3, 1,1,3);
    add(0,1,3, 1,1,3); add(0,1,3, 0,1,3); add(0,1,3, 0,0,0); add(0,1,3, 0,0,0);
    // Mute and code change together: mute wins.
    add(0,0,1, 0,0,0); add(0,0,1, 0,0,0); add(0,0,1, 1,1,1); add(0,0,1, 1,1,1);
    add(0,1,2, 1,1,1); add(0,1,2, 1,1,1); add(0,1,2, 0,0,0); add(0,1,2, 0,0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
    end

    // Reset mid-tone: silent on the reset edge, tone returns 3 clocks after release.
    hand(0,0,2, 0,0,0); hand(0,0,2, 0,0,0); hand(0,0,2, 1,1,2); hand(0,0,2, 1,1,2);
    hand(1,0,2, 0,0,0);
    hand(0,0,2, 0,0,0); hand(0,0,2, 0,0,0); hand(0,0,2, 1,1,2);
    hand(0,0,2, 1,1,2); hand(0,0,2, 0,1,2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pong_sound.md
PONG_SOUND -- requirements
Module: pong_sound

Interface
- REQ-001: Parameter HALF_WALL, default 25000, clk cycles per half-period of the wall-bounce tone (500 Hz at 25 MHz).
- REQ-002: Parameter HALF_PADDLE, default 12500, clk cycles per half-period of the paddle-bounce tone (1 kHz).
- REQ-003: Parameter HALF_GOAL_HI, default 50000, clk cycles per half-period of the first goal note (250 Hz).
- REQ-004: Parameter HALF_GOAL_LO, default 100000, clk cycles per half-period of the second goal note (125 Hz).
- REQ-005: Parameter GOAL_STEP, default 2500000, clk cycles the first goal note lasts (100 ms).
- REQ-006: clk  input  1  system clock; the only clock in the block.
- REQ-007: reset  input  1  synchronous, active-high reset.
- REQ-008: mute  input  1  silence request from the game-dynamics block; asynchronous to clk.
- REQ-009: sound  input  2  sound code from the game-dynamics block (0 none, 1 wall, 2 paddle, 3 goal); asynchronous to clk.
- REQ-010: buzzer  output  1  square-wave drive for the speaker pin.
- REQ-011: busy  output  1  high while a tone is playing.
- REQ-012: code_q  output  2  sound code currently playing; 0 when idle.

Function
- REQ-013: mute and sound SHALL each pass through a two-flop synchronizer on clk; all decisions SHALL use only the synchronized values (mute_s, sound_s).
- REQ-014: The state machine SHALL have exactly four states: IDLE, TONE, GOAL_HI and GOAL_LO.
- REQ-015: In IDLE, when mute_s=0 and sound_s is 1 or 2, the block SHALL enter TONE on the next clock and latch code_q=sound_s.
- REQ-016: In IDLE, when mute_s=0 and sound_s=3, the block SHALL enter GOAL_HI and latch code_q=3.
- REQ-017: In IDLE, when mute_s=0 and sound_s=0, the block SHALL remain in IDLE.
- REQ-018: Entering any tone state SHALL clear the half-period counter and the step counter and set buzzer=1.
- REQ-019: The half-period limit SHALL be HALF_WALL when code_q=1, HALF_PADDLE when code_q=2, HALF_GOAL_HI in GOAL_HI, and HALF_GOAL_LO in GOAL_LO.
- REQ-020: The half-period counter SHALL increment every clock; on reaching limit-1 it SHALL wrap to 0 and toggle buzzer.
- REQ-021: In GOAL_HI, the step counter SHALL count clocks; when it reaches GOAL_STEP-1 the block SHALL go to GOAL_LO with the half-period counter cleared and buzzer=1.
- REQ-022: The block SHALL stay in GOAL_LO until it is stopped by REQ-023 or restarted by REQ-024.
- REQ-023: From any tone state, mute_s=1 SHALL return the block to IDLE on the next clock with buzzer=0, busy=0 and code_q=0.
- REQ-024: From any tone state, when mute_s=0 and sound_s differs from code_q and is nonzero, the block SHALL restart per REQ-015/REQ-016 with the new code on the next clock.
- REQ-025: When mute_s=1 and a code change occur on the same cycle, mute_s=1 SHALL win.
- REQ-026: sound_s=0 while mute_s=0 in a tone state SHALL be treated as a stop, with the same behaviour as REQ-023.
- REQ-027: In IDLE, buzzer SHALL be 0 and busy SHALL be 0; in every tone state busy SHALL be 1.
- REQ-028: Counters SHALL be sized to hold the largest parameter minus 1 without overflow.
- REQ-029: Latency from a change on the mute pin to a change on buzzer/busy SHALL be at most 3 clocks (2 synchronizer flops plus 1 state register).
- REQ-030: All outputs SHALL be registered.

Reset
- REQ-031: On a clk edge with reset=1: state=IDLE, buzzer=0, busy=0, code_q=0, all counters 0, synchronizer flops set to mute=1 and sound=0.
- REQ-032: Asserting reset mid-tone SHALL silence buzzer on that same clock edge.
- REQ-033: After reset is released, the block SHALL respond only to fresh synchronized inputs.

Verification (HALF_WALL=4, HALF_PADDLE=2, HALF_GOAL_HI=3, HALF_GOAL_LO=5, GOAL_STEP=12)
- REQ-034: reset, then mute=0, sound=1 held -> busy=1 and code_q=1 within 3 clocks; buzzer toggles every 4 clocks.
- REQ-035: sound=3, mute=0 held -> buzzer toggles every 3 clocks for 12 clocks, then toggles every 5 clocks with code_q still 3.
- REQ-036: sound=1 playing, sound changes to 2 -> restart with buzzer=1, code_q=2, and toggling every 2 clocks.
- REQ-037: mute=1 during GOAL_HI -> buzzer=0, busy=0 and code_q=0 within 3 clocks.
- REQ-038: reset pulsed mid-tone with mute=0, sound=2 -> outputs are 0 on the reset edge, and the tone restarts 3 clocks after reset is released.
